// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer: halts the pipeline, walks the register file through its
// async read port and streams a header byte plus every register, MSB byte first, to UART TX.
module regfile_dump_ctrl #(
  parameter int         LEN         = 32,
  parameter int         NB_REG      = 32,
  parameter int         NB_ADDR     = 5,
  parameter int         HALT_CYCLES = 2,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_dump_req,
  output logic               o_pipe_enable,
  output logic [NB_ADDR-1:0] o_rf_addr,
  input  logic [LEN-1:0]     i_rf_data,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);
  localparam int NBYTES = LEN / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int HC_W   = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, HALT, HDR, LOAD, SEND, DONE} state_t;

  state_t             state;
  logic [HC_W-1:0]    halt_cnt;
  logic [BC_W-1:0]    byte_cnt;
  logic [NB_ADDR-1:0] idx;
  logic [LEN-1:0]     shreg;
  logic [LEN-1:0]     sh_next;
  logic               xfer;

  assign xfer    = o_tx_valid & i_tx_ready;
  assign sh_next = shreg << 8;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= IDLE;
      o_pipe_enable <= 1'b1;
      o_rf_addr     <= '0;
      o_tx_data     <= '0;
      o_tx_valid    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      halt_cnt      <= '0;
      byte_cnt      <= '0;
      idx           <= '0;
      shreg         <= '0;
    end else begin
      case (state)
        IDLE: if (i_dump_req) begin
          state         <= HALT;
          halt_cnt      <= '0;
          o_pipe_enable <= 1'b0;
          o_busy        <= 1'b1;
        end
        // Halt wait lets a write already in flight on the RF negedge port land.
        HALT: if (halt_cnt == HC_W'(HALT_CYCLES - 1)) begin
          state      <= HDR;
          o_tx_data  <= HEADER;
          o_tx_valid <= 1'b1;
        end else begin
          halt_cnt <= halt_cnt + HC_W'(1);
        end
        HDR: if (xfer) begin
          state      <= LOAD;
          o_tx_valid <= 1'b0;
          idx        <= '0;
          o_rf_addr  <= '0;
        end
        // Address was registered on entry, so the async read data is settled here.
        LOAD: begin
          shreg      <= i_rf_data;
          o_tx_data  <= i_rf_data[LEN-1 -: 8];
          o_tx_valid <= 1'b1;
          byte_cnt   <= '0;
          state      <= SEND;
        end
        SEND: if (xfer) begin
          if (byte_cnt == BC_W'(NBYTES - 1)) begin
            o_tx_valid <= 1'b0;
            if (idx == NB_ADDR'(NB_REG - 1)) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              idx       <= idx + NB_ADDR'(1);
              o_rf_addr <= idx + NB_ADDR'(1);
              state     <= LOAD;
            end
          end else begin
            shreg     <= sh_next;
            o_tx_data <= sh_next[LEN-1 -: 8];
            byte_cnt  <= byte_cnt + BC_W'(1);
          end
        end
        DONE: begin
          o_done        <= 1'b0;
          o_busy        <= 1'b0;
          o_pipe_enable <= 1'b1;
          idx           <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: table of dump scenarios checked against
// an RF model byte stream, plus hand sequences for held request and mid-dump reset.
module tb_regfile_dump_ctrl;
  localparam int LEN = 32, NB_REG = 32, NB_ADDR = 5, NBYTES = 4;
  localparam int NTOT = 1 + NB_REG * NBYTES;

  logic clk = 1'b0, rst = 1'b0, req = 1'b0, tx_ready = 1'b1;
  logic pipe_en, tx_valid, busy, done;
  logic [NB_ADDR-1:0] rf_addr;
  logic [LEN-1:0]     rf_data;
  logic [7:0]         tx_data;
  logic [LEN-1:0]     rf [NB_REG];

  assign rf_data = rf[rf_addr];

  regfile_dump_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_dump_req(req), .o_pipe_enable(pipe_en),
    .o_rf_addr(rf_addr), .i_rf_data(rf_data), .o_tx_data(tx_data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // Passive monitor: capture transfers, handshake stability, enable/busy relation, done pulses.
  logic [7:0] cap[$];
  int   stab_bad = 0, en_bad = 0, done_cnt = 0, done_edge = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst) prev_stall <= 1'b0;
    else begin
      if (tx_valid && tx_ready) cap.push_back(tx_data);
      if (prev_stall && (!tx_valid || tx_data != prev_data)) stab_bad <= stab_bad + 1;
      if (pipe_en == busy) en_bad <= en_bad + 1;
      if (done) begin done_cnt <= done_cnt + 1; done_edge <= ecnt; end
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end
  end

  bit rnd_mode = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit    rnd;
    int    extra;
    bit    wr3;
    int    done_off;
    string name;
  } vec_t;
  vec_t vt[4];

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (done_cnt != d0) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic check_stream(input string nm, input int base);
    logic [7:0] exp[$];
    exp.push_back(8'hA5);
    for (int k = 0; k < NB_REG; k++)
      for (int b = NBYTES - 1; b >= 0; b--) exp.push_back(rf[k][8*b +: 8]);
    check({nm, "_nbytes"}, cap.size() - base, NTOT);
    for (int i = 0; i < NTOT; i++)
      if (base + i < cap.size()) check($sformatf("%s_byte%0d", nm, i), cap[base+i], exp[i]);
  endtask

  task automatic run_dump(input vec_t v);
    int d0, e0, base, sb0, eb0;
    bit ok;
    rnd_mode = v.rnd;
    d0 = done_cnt; base = cap.size(); sb0 = stab_bad; eb0 = en_bad;
    req = 1'b1;
    tick();
    e0 = ecnt;
    req = 1'b0;
    if (v.wr3) rf[3] = 32'hDEADBEEF;
    for (int i = 0; i < v.extra; i++) begin
      tick(); tick(); tick();
      req = 1'b1; tick(); req = 1'b0;
    end
    wait_done(d0, ok);
    if (!ok) return;
    if (v.done_off >= 0) check({v.name, "_done_edge"}, done_edge - e0, v.done_off);
    tick(); tick(); tick();
    check({v.name, "_one_done"}, done_cnt - d0, 1);
    check({v.name, "_idle_busy"}, busy, 0);
    check({v.name, "_idle_en"}, pipe_en, 1);
    check({v.name, "_hold_stable"}, stab_bad - sb0, 0);
    check({v.name, "_en_vs_busy"}, en_bad - eb0, 0);
    check_stream(v.name, base);
    if (v.wr3 && cap.size() >= base + 17) begin
      check("wr3_b0", cap[base+13], 8'hDE);
      check("wr3_b1", cap[base+14], 8'hAD);
      check("wr3_b2", cap[base+15], 8'hBE);
      check("wr3_b3", cap[base+16], 8'hEF);
    end
    rnd_mode = 1'b0;
  endtask

  initial begin
    int  d0, e0, base;
    bit  ok;
    for (int k = 0; k < NB_REG; k++) rf[k] = LEN'(k);
    vt[0] = '{rnd: 1'b0, extra: 0, wr3: 1'b0, done_off: 163, name: "basic"};
    vt[1] = '{rnd: 1'b1, extra: 0, wr3: 1'b0, done_off: -1,  name: "stall"};
    vt[2] = '{rnd: 1'b0, extra: 6, wr3: 1'b0, done_off: 163, name: "extra_req"};
    vt[3] = '{rnd: 1'b0, extra: 0, wr3: 1'b1, done_off: 163, name: "rf_write"};

    rst = 1'b0;
    tick(); tick(); tick();
    check("rst_en", pipe_en, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_done", done, 0);
    check("rst_addr", rf_addr, 0);
    check("rst_data", tx_data, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_dump(vt[i]);
      rf[3] = 32'd3;
    end

    // Reset while sending register 7 aborts; a fresh request starts over at the header.
    ok = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (rf_addr == 5'd7 && tx_valid) begin ok = 1'b1; break; end
      tick();
    end
    check("reach_reg7", ok, 1);
    tick();
    rst = 1'b0;
    tick();
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_en", pipe_en, 1);
    check("abort_addr", rf_addr, 0);
    check("abort_done", done, 0);
    rst = 1'b1;
    tick();
    run_dump('{rnd: 1'b0, extra: 0, wr3: 1'b0, done_off: 163, name: "restart"});

    // Request held high: one full dump, then a second one starts from IDLE.
    d0 = done_cnt; base = cap.size();
    req = 1'b1;
    tick();
    e0 = ecnt;
    wait_done(d0, ok);
    if (ok) begin
      check("held_done_edge", done_edge - e0, 163);
      check("held_nbytes", cap.size() - base, NTOT);
      check("held_idle_busy", busy, 0);
      check("held_idle_en", pipe_en, 1);
      tick();
      check("held_rearm_busy", busy, 1);
      check("held_rearm_en", pipe_en, 0);
    end
    req = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
